cursor_ctrl: RTL

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/cursor_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cursor_ctrl.sv
// Cursor position controller: accepts relative-motion packets, scales/accelerates
// them, and applies a clamped update to the cursor centre over three cycles.
module cursor_ctrl #(
  parameter int COORD_W      = 10,
  parameter int DISPL_W      = 9,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int SIZE         = 4,
  parameter int SHIFT        = 0,
  parameter int ACCEL_THRESH = 16,
  parameter int Y_INVERT     = 0
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [DISPL_W-1:0] X_displ,
  input  logic [DISPL_W-1:0] Y_displ,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               accel_en,
  input  logic               recenter,
  output logic [COORD_W-1:0] X_pos,
  output logic [COORD_W-1:0] Y_pos,
  output logic [COORD_W-1:0] Size,
  output logic               moved,
  output logic               draw,
  output logic               erase
);

  localparam int MW = DISPL_W + 1;            // magnitude may double
  localparam int AW = COORD_W + DISPL_W + 2;  // signed sum, never wraps

  typedef enum logic [1:0] {IDLE, SCALE, APPLY} state_t;

  state_t             state_q, state_d;
  logic [DISPL_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic               bl_q, bl_d, br_q, br_d, acc_q, acc_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic [MW-1:0]      mx_q, mx_d, my_q, my_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               moved_q, moved_d, draw_q, draw_d, erase_q, erase_d;
  logic               pend_q, pend_d;

  // Returns {negative, magnitude}; widened by one bit so negating -2^(W-1) is exact.
  function automatic logic [MW:0] scale(input logic [DISPL_W-1:0] d, input logic inv,
                                        input logic acc);
    logic signed [DISPL_W:0] e;
    logic [DISPL_W-1:0]      a;
    logic [MW-1:0]           m;
    logic                    neg;
    e   = {d[DISPL_W-1], d};
    if (inv) e = -e;
    neg = e[DISPL_W];
    a   = neg ? DISPL_W'(-e) : DISPL_W'(e);
    m   = MW'(a >> SHIFT);
    if (acc && (m >= MW'(ACCEL_THRESH))) m = m << 1;
    return {neg, m};
  endfunction

  function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] p, input logic neg,
                                              input logic [MW-1:0] m, input int mx);
    logic signed [AW-1:0] pe, me, s, lo, hi;
    pe = AW'(p);
    me = AW'(m);
    lo = AW'(SIZE);
    hi = AW'(mx - SIZE);
    s  = neg ? pe - me : pe + me;
    if (s < lo)      s = lo;
    else if (s > hi) s = hi;
    return s[COORD_W-1:0];
  endfunction

  // Recenter (live or pending) blocks acceptance so it always wins in IDLE.
  assign pkt_ready = (state_q == IDLE) && !pend_q && !recenter;

  always_comb begin
    state_d = state_q;
    dx_d = dx_q;  dy_d = dy_q;
    bl_d = bl_q;  br_d = br_q;  acc_d = acc_q;
    sx_d = sx_q;  sy_d = sy_q;  mx_d = mx_q;  my_d = my_q;
    x_d = x_q;    y_d = y_q;
    moved_d = 1'b0;
    draw_d = draw_q;  erase_d = erase_q;
    pend_d = pend_q;
    unique case (state_q)
      IDLE: begin
        if (recenter || pend_q) begin
          x_d     = COORD_W'(X_CENTER);
          y_d     = COORD_W'(Y_CENTER);
          moved_d = 1'b1;
          pend_d  = 1'b0;
        end else if (pkt_valid) begin
          state_d = SCALE;
          dx_d = X_displ;   dy_d = Y_displ;
          bl_d = btn_left;  br_d = btn_right;  acc_d = accel_en;
        end
      end
      SCALE: begin
        state_d      = APPLY;
        {sx_d, mx_d} = scale(dx_q, 1'b0, acc_q);
        {sy_d, my_d} = scale(dy_q, Y_INVERT != 0, acc_q);
        if (recenter) pend_d = 1'b1;
      end
      APPLY: begin
        state_d = IDLE;
        x_d     = step(x_q, sx_q, mx_q, X_MAX);
        y_d     = step(y_q, sy_q, my_q, Y_MAX);
        draw_d  = bl_q;
        erase_d = br_q & ~bl_q;
        moved_d = 1'b1;
        if (recenter) pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dx_q <= '0;  dy_q <= '0;
      bl_q <= 1'b0;  br_q <= 1'b0;  acc_q <= 1'b0;
      sx_q <= 1'b0;  sy_q <= 1'b0;  mx_q <= '0;  my_q <= '0;
      x_q <= COORD_W'(X_CENTER);
      y_q <= COORD_W'(Y_CENTER);
      moved_q <= 1'b0;  draw_q <= 1'b0;  erase_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q <= dx_d;  dy_q <= dy_d;
      bl_q <= bl_d;  br_q <= br_d;  acc_q <= acc_d;
      sx_q <= sx_d;  sy_q <= sy_d;  mx_q <= mx_d;  my_q <= my_d;
      x_q <= x_d;    y_q <= y_d;
      moved_q <= moved_d;  draw_q <= draw_d;  erase_q <= erase_d;
      pend_q <= pend_d;
    end
  end

  assign X_pos = x_q;
  assign Y_pos = y_q;
  assign Size  = COORD_W'(SIZE);
  assign moved = moved_q;
  assign draw  = draw_q;
  assign erase = erase_q;

endmodule
